uwasic_onboarding_daniel_lee: RTL and testbench
===============================================

Name: uwasic_onboarding_daniel_lee

Overview:
Tiny Tapeout user block with two parts:
- an SPI-write-only register file (5 x 8-bit registers);
- a 16-channel output driver. Each channel is forced low, driven high, or driven by a shared PWM waveform, as selected by the registers.

The SPI interface is on the dedicated inputs. The 16 channels drive uo_out and uio_out.

Parameters:
- CLK_DIV, 13, prescaler divisor for the PWM counter tick. With a 10 MHz clk this gives 10e6/13/256 ≈ 3.0 kHz PWM.
- SYNC_STAGES, 2, flip-flop stages on each asynchronous SPI input.

Ports:
- clk  in  1  system clock (10 MHz nominal).
- rst_n  in  1  asynchronous reset.
  - One clock domain; reset is asynchronous and active-high: asserted when 1, despite the codebase port name.
- ena  in  1  design-selected flag; ignored.
- ui_in  in  8  SPI input bits:
  - [0] SCLK
  - [1] COPI
  - [2] nCS (active low)
  - [7:3] unused.
- uio_in  in  8  unused.
- uo_out  out  8  output channels 7..0.
- uio_out  out  8  output channels 15..8.
- uio_oe  out  8  constant 8'hFF (all bidirectional pins are outputs).

Behaviour:
- Reset: all five registers = 8'h00. Consequently uo_out = uio_out = 8'h00. Synchronizers, shift register, bit counter and PWM counters are cleared. uio_oe = 8'hFF at all times.
- Registers and addresses:
  - 0x00 en_out[7:0]
  - 0x01 en_out[15:8]
  - 0x02 en_pwm[7:0]
  - 0x03 en_pwm[15:8]
  - 0x04 duty
- SPI input synchronization: SCLK, COPI and nCS each pass through SYNC_STAGES flip-flops. Edges are detected on the synchronized signals. SCLK must be ≤ clk/4.
- SPI frame:
  - Mode 0. COPI is sampled on the synchronized SCLK rising edge while nCS is low. MSB first.
  - The synchronized nCS falling edge clears the shift register and bit counter.
  - Frame layout: bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
- Commit: on the synchronized nCS rising edge, commit data to the register at address only if:
  - exactly 16 bits were received,
  - R/W = 1,
  - address ≤ 0x04.
  - The register updates on the clk edge that detects the nCS rise.
- Frames that are not committed: reads (R/W = 0), address > 0x04, and frames of fewer than 16 bits are discarded. Bits beyond 16 saturate the counter and discard the frame. Registers are unchanged in all these cases.
- Reset mid-frame: the frame is discarded.
- PWM timing:
  - The prescaler counts 0..CLK_DIV-1 and emits a one-cycle tick at wrap.
  - An 8-bit counter increments on each tick and wraps 255→0.
  - pwm = (duty == 8'hFF) ? 1 : (counter < duty). So duty 0x00 gives constant 0 and 0xFF gives constant 1.
  - Period = 256·CLK_DIV clk cycles.
- Channel i output = en_out[i] ? (en_pwm[i] ? pwm : 1) : 0. The output is registered, so there is one cycle of latency from register or pwm change.
- A duty change takes effect at the next counter comparison, with no period restart.

Decomposition:
- Package holds:
  - address constants ADDR_EN_OUT_LO..ADDR_DUTY (0x00–0x04);
  - MAX_ADDR = 0x04;
  - FRAME_BITS = 16.
- One sub-module, spi_peripheral. It contains the synchronizers, shift register, bit counter, commit logic and five register outputs.
- The PWM prescaler/counter and output mux stay in the top module.

Test Plan:
- Reset: assert rst_n = 1 for 5 cycles, then release → uo_out = 0x00, uio_out = 0x00, uio_oe = 0xFF.
- Static enable: write 0x00 ← 0xF0 and 0x01 ← 0x01 → uo_out = 0xF0, uio_out = 0x01 within 5 clk after nCS rise.
- Discarded frames, starting from that state:
  - read frame (bit15 = 0) to 0x00 with data 0xFF → no change;
  - write to address 0x30 → no change;
  - 15-bit write to 0x00 → no change.
- PWM duty, with 0x00 ← 0x01, 0x02 ← 0x01, 0x04 ← 0x80:
  - uo_out[0] period = 3328 clk (±1); high time = 1664 clk (50%).
  - duty 0x00 → constant 0 over 2 periods.
  - duty 0xFF → constant 1 over 2 periods.
- PWM without output enable: 0x02 ← 0x01 with 0x00 = 0x00 → uo_out[0] stays 0. Set 0x00 ← 0x01 → uo_out[0] toggles.
- Reset mid-frame: assert reset after 8 SPI bits of a write 0x00 ← 0xFF, then release, raise nCS → all registers 0x00, outputs 0x00.

Source files
------------

// File: rtl/uwasic_onboarding_daniel_lee_pkg.sv
// Shared constants, register-file layout and frame-acceptance helper for the
// SPI-programmed 16-channel PWM driver.
package uwasic_onboarding_daniel_lee_pkg;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;
  localparam logic [6:0] MAX_ADDR       = 7'h04;

  localparam int FRAME_BITS = 16;
  localparam int CNT_W      = 5;

  typedef struct packed {
    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic [7:0]  duty;
  } reg_file_t;

  // A frame is accepted only when it is a complete write to an existing register.
  function automatic logic frame_ok(input logic [CNT_W-1:0] count, input logic [15:0] frame);
    return (count == CNT_W'(FRAME_BITS)) && frame[15] && (frame[14:8] <= MAX_ADDR);
  endfunction

endpackage

// File: rtl/uwasic_onboarding_daniel_lee_spi_peripheral.sv
// Write-only SPI (mode 0, MSB first) slave: input synchronizers, 16-bit frame
// capture and commit into the five configuration registers.
module uwasic_onboarding_daniel_lee_spi_peripheral
  import uwasic_onboarding_daniel_lee_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      sclk,
  input  logic      copi,
  input  logic      ncs,
  output reg_file_t regs
);

  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(FRAME_BITS + 1);

  // One extra stage on sclk/ncs keeps the previous synchronized value for edge detection.
  logic [SYNC_STAGES:0]   sclk_sync_r;
  logic [SYNC_STAGES:0]   ncs_sync_r;
  logic [SYNC_STAGES-1:0] copi_sync_r;
  logic [15:0]            shift_r;
  logic [CNT_W-1:0]       count_r;

  logic sclk_rise_s;
  logic ncs_fall_s;
  logic ncs_rise_s;
  logic ncs_low_s;
  logic copi_s;

  // Synchronizer chains for the asynchronous SPI pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_r <= '0;
      ncs_sync_r  <= '0;
      copi_sync_r <= '0;
    end else begin
      sclk_sync_r[0] <= sclk;
      ncs_sync_r[0]  <= ncs;
      copi_sync_r[0] <= copi;
      for (int i = 1; i <= SYNC_STAGES; i++) begin
        sclk_sync_r[i] <= sclk_sync_r[i-1];
        ncs_sync_r[i]  <= ncs_sync_r[i-1];
      end
      for (int i = 1; i < SYNC_STAGES; i++) begin
        copi_sync_r[i] <= copi_sync_r[i-1];
      end
    end
  end

  assign sclk_rise_s = sclk_sync_r[SYNC_STAGES-1] & ~sclk_sync_r[SYNC_STAGES];
  assign ncs_fall_s  = ~ncs_sync_r[SYNC_STAGES-1] & ncs_sync_r[SYNC_STAGES];
  assign ncs_rise_s  = ncs_sync_r[SYNC_STAGES-1] & ~ncs_sync_r[SYNC_STAGES];
  assign ncs_low_s   = ~ncs_sync_r[SYNC_STAGES-1];
  assign copi_s      = copi_sync_r[SYNC_STAGES-1];

  // Frame capture; the counter saturates one past a full frame so overlong frames never commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_r <= 16'h0000;
      count_r <= '0;
    end else if (ncs_fall_s) begin
      shift_r <= 16'h0000;
      count_r <= '0;
    end else if (sclk_rise_s && ncs_low_s) begin
      shift_r <= {shift_r[14:0], copi_s};
      if (count_r != CNT_SAT) begin
        count_r <= count_r + CNT_W'(1);
      end
    end
  end

  // Register commit on the end of a valid frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '0;
    end else if (ncs_rise_s && frame_ok(count_r, shift_r)) begin
      case (shift_r[14:8])
        ADDR_EN_OUT_LO: regs.en_out[7:0]  <= shift_r[7:0];
        ADDR_EN_OUT_HI: regs.en_out[15:8] <= shift_r[7:0];
        ADDR_EN_PWM_LO: regs.en_pwm[7:0]  <= shift_r[7:0];
        ADDR_EN_PWM_HI: regs.en_pwm[15:8] <= shift_r[7:0];
        ADDR_DUTY:      regs.duty         <= shift_r[7:0];
        default:        regs              <= regs;
      endcase
    end
  end

endmodule

// File: rtl/uwasic_onboarding_daniel_lee.sv
// Tiny Tapeout top: SPI-configured 16-channel driver, each channel off, on or
// following a shared 8-bit PWM waveform.
module uwasic_onboarding_daniel_lee
  import uwasic_onboarding_daniel_lee_pkg::*;
#(
  parameter int CLK_DIV     = 13,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int PRESC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_DIV - 1);

  reg_file_t          regs;
  logic [PRESC_W-1:0] presc_r;
  logic [7:0]         pwm_cnt_r;
  logic [15:0]        out_r;
  logic               tick_s;
  logic               pwm_s;
  logic [15:0]        chan_s;
  logic               unused_inputs;

  // rst_n is active-high despite its name.
  uwasic_onboarding_daniel_lee_spi_peripheral #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_spi (
    .clk  (clk),
    .rst  (rst_n),
    .sclk (ui_in[0]),
    .copi (ui_in[1]),
    .ncs  (ui_in[2]),
    .regs (regs)
  );

  assign tick_s = (presc_r == PRESC_MAX);

  // Prescaler and PWM counter.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      presc_r   <= '0;
      pwm_cnt_r <= 8'h00;
    end else if (tick_s) begin
      presc_r   <= '0;
      pwm_cnt_r <= pwm_cnt_r + 8'h01;
    end else begin
      presc_r   <= presc_r + PRESC_W'(1);
    end
  end

  assign pwm_s  = (regs.duty == 8'hFF) | (pwm_cnt_r < regs.duty);
  assign chan_s = regs.en_out & (~regs.en_pwm | {16{pwm_s}});

  // Registered channel outputs.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      out_r <= 16'h0000;
    end else begin
      out_r <= chan_s;
    end
  end

  assign uo_out        = out_r[7:0];
  assign uio_out       = out_r[15:8];
  assign uio_oe        = 8'hFF;
  assign unused_inputs = ^{ena, uio_in, ui_in[7:3]};

endmodule

// File: tb/tb_uwasic_onboarding_daniel_lee.sv
// Directed self-checking bench: SPI register writes, discarded frames, PWM
// timing and reset behaviour observed on the channel outputs.
module tb_uwasic_onboarding_daniel_lee;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;
  int cyc_a;
  int cyc_b;
  int ones;

  localparam int PERIOD = 3328;

  uwasic_onboarding_daniel_lee dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Shift nbits of word MSB first; bits past 16 are zeros.
  task automatic spi_bits(input logic [15:0] word, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ui_in[1] = (i < 16) ? word[15-i] : 1'b0;
      repeat (4) @(negedge clk);
      ui_in[0] = 1'b1;
      repeat (4) @(negedge clk);
      ui_in[0] = 1'b0;
    end
  endtask

  // Full frame; returns 5 clk after nCS rise, on a falling edge.
  task automatic spi_frame(input logic [15:0] word, input int nbits);
    ui_in[2] = 1'b0;
    repeat (4) @(negedge clk);
    spi_bits(word, nbits);
    repeat (4) @(negedge clk);
    ui_in[2] = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_ch0(input logic lvl, input int max, output int cycles);
    cycles = 0;
    while (uo_out[0] !== lvl && cycles < max) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic count_ch0(input int n, output int high);
    high = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (uo_out[0] === 1'b1) high++;
    end
  endtask

  initial begin
    ena    = 1'b1;
    uio_in = 8'h00;
    ui_in  = 8'h04;
    rst_n  = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_uo", 32'(uo_out), 32'h00);
    check("reset_uio", 32'(uio_out), 32'h00);
    check("reset_oe", 32'(uio_oe), 32'hFF);

    spi_frame(16'h80F0, 16);
    spi_frame(16'h8101, 16);
    check("static_uo", 32'(uo_out), 32'hF0);
    check("static_uio", 32'(uio_out), 32'h01);

    spi_frame(16'h00FF, 16);
    check("read_uo", 32'(uo_out), 32'hF0);
    check("read_uio", 32'(uio_out), 32'h01);
    spi_frame(16'hB0FF, 16);
    check("badaddr_uo", 32'(uo_out), 32'hF0);
    check("badaddr_uio", 32'(uio_out), 32'h01);
    spi_frame(16'h80FF, 15);
    check("short_uo", 32'(uo_out), 32'hF0);
    spi_frame(16'h80FF, 17);
    check("long_uo", 32'(uo_out), 32'hF0);

    spi_frame(16'h8001, 16);
    spi_frame(16'h8201, 16);
    spi_frame(16'h8480, 16);
    wait_ch0(1'b0, 4000, cyc_a);
    check("pwm_fall_timeout", 32'(cyc_a < 4000), 32'h1);
    wait_ch0(1'b1, 4000, cyc_a);
    check("pwm_rise_timeout", 32'(cyc_a < 4000), 32'h1);
    wait_ch0(1'b0, 4000, cyc_a);
    wait_ch0(1'b1, 4000, cyc_b);
    check("pwm_high_time", 32'(cyc_a), 32'd1664);
    check("pwm_period", 32'(cyc_a + cyc_b), 32'(PERIOD));
    check("pwm_other_bits", 32'(uo_out[7:1]), 32'h00);
    check("pwm_uio", 32'(uio_out), 32'h01);

    spi_frame(16'h8400, 16);
    count_ch0(2 * PERIOD, ones);
    check("duty00_high", 32'(ones), 32'd0);
    spi_frame(16'h84FF, 16);
    count_ch0(2 * PERIOD, ones);
    check("dutyFF_high", 32'(ones), 32'(2 * PERIOD));

    spi_frame(16'h8480, 16);
    spi_frame(16'h8000, 16);
    count_ch0(2 * PERIOD, ones);
    check("noen_high", 32'(ones), 32'd0);
    spi_frame(16'h8001, 16);
    count_ch0(PERIOD, ones);
    check("en_toggle_high", 32'(ones), 32'd1664);

    ui_in[2] = 1'b0;
    repeat (4) @(negedge clk);
    spi_bits(16'h80FF, 8);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    spi_bits(16'hFF00, 8);
    repeat (4) @(negedge clk);
    ui_in[2] = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("midreset_uo", 32'(uo_out), 32'h00);
    check("midreset_uio", 32'(uio_out), 32'h00);
    spi_frame(16'h8001, 16);
    count_ch0(64, ones);
    check("midreset_pwm_cleared", 32'(ones), 32'd64);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
